// File: rtl/keccak_absorb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_absorb_pkg
// Description : Shared types and constants for the Keccak sponge absorb
//               front-end (FSM state encoding, state/word widths, pad byte).
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_absorb_pkg;

    localparam int STATE_W = 1600;
    localparam int WORD_W  = 32;
    localparam logic [7:0] PAD_LAST = 8'h80;

    typedef enum logic [2:0] {
        ST_ABSORB = 3'd0,
        ST_PAD    = 3'd1,
        ST_PERM   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Keep the low nbytes bytes of a little-endian word; 4 or more keeps all.
    function automatic logic [WORD_W-1:0] byte_mask(input logic [2:0] nbytes);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = (nbytes > 3'(k)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage : keccak_absorb_pkg
`default_nettype wire

// File: rtl/keccak_pad_gen.sv
`default_nettype none
// ============================================================================
// Module      : keccak_pad_gen
// Description : Combinational pad10*1 vector generator. Places the
//               domain-separation byte at byte offset p and 0x80 at the last
//               rate byte; both XOR together when they coincide. A p equal to
//               the full rate selects no byte for the separator.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_pad_gen
    import keccak_absorb_pkg::*;
#(
    parameter int         RATE_W = 42,
    parameter logic [7:0] DSEP   = 8'h1F
) (
    input  logic [7:0]         p_i,
    output logic [STATE_W-1:0] pad_o
);

    localparam int RATE_B = 4 * RATE_W;

    generate
        for (genvar b = 0; b < RATE_B; b++) begin : g_byte
            localparam logic [7:0] LAST_BYTE = (b == RATE_B - 1) ? PAD_LAST : 8'h00;
            assign pad_o[8*b +: 8] = ((p_i == 8'(b)) ? DSEP : 8'h00) ^ LAST_BYTE;
        end
        if (RATE_B < STATE_W / 8) begin : g_capacity
            assign pad_o[STATE_W-1:8*RATE_B] = '0;
        end
    endgenerate

endmodule : keccak_pad_gen
`default_nettype wire

// File: rtl/keccak_absorb.sv
`default_nettype none
// ============================================================================
// Module      : keccak_absorb
// Description : Sponge absorb front-end for Keccak-f[1600]. XORs 32-bit
//               message words into the rate part of the state, optionally
//               applies pad10*1 with a domain-separation byte, hands the
//               state to the permutation core and captures its result.
//               Build option: define KECCAK_ABSORB_PAD_EN for hardware
//               padding; otherwise blocks are expected pre-padded.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_absorb
    import keccak_absorb_pkg::*;
#(
    parameter int         RATE_W = 42,
    parameter logic [7:0] DSEP   = 8'h1F
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               msg_valid_i,
    output logic               msg_ready_o,
    input  logic [31:0]        msg_data_i,
    input  logic [2:0]         msg_bytes_i,
    input  logic               msg_last_i,
    output logic               perm_start_o,
    output logic [STATE_W-1:0] perm_din_o,
    input  logic [STATE_W-1:0] perm_dout_i,
    input  logic               perm_done_i,
    output logic               digest_valid_o,
    output logic [STATE_W-1:0] digest_o,
    input  logic               digest_ready_i
);

    localparam logic [5:0] IDX_LAST = 6'(RATE_W - 1);

    state_e               fsm_q, fsm_d;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic                 final_q, final_d;

    logic                 accept;
    logic [2:0]           eff_bytes;
    logic [WORD_W-1:0]    word_masked;
    logic [STATE_W-1:0]   word_vec;

`ifdef KECCAK_ABSORB_PAD_EN
    localparam logic [7:0] P_FULL = 8'(4 * RATE_W);

    logic [7:0]           p_q, p_d;
    logic                 pad_pending_q, pad_pending_d;
    logic [7:0]           p_new;
    logic [STATE_W-1:0]   pad_vec;

    assign eff_bytes = msg_last_i ? msg_bytes_i : 3'd4;
    assign p_new     = {idx_q, 2'b00} + {5'd0, eff_bytes};

    keccak_pad_gen #(
        .RATE_W (RATE_W),
        .DSEP   (DSEP)
    ) u_pad_gen (
        .p_i   (p_q),
        .pad_o (pad_vec)
    );
`else
    // Byte count is meaningless without hardware padding.
    logic unused_bytes;
    assign unused_bytes = ^msg_bytes_i;
    assign eff_bytes    = 3'd4;
`endif

    assign accept      = msg_valid_i & msg_ready_o;
    assign word_masked = msg_data_i & byte_mask(eff_bytes);

    // Place the masked word at the current rate slot, zero elsewhere.
    generate
        for (genvar g = 0; g < RATE_W; g++) begin : g_word
            assign word_vec[WORD_W*g +: WORD_W] = (idx_q == 6'(g)) ? word_masked : '0;
        end
        if (RATE_W < STATE_W / WORD_W) begin : g_word_tail
            assign word_vec[STATE_W-1:WORD_W*RATE_W] = '0;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q <= ST_ABSORB;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_ABSORB: begin
                if (accept) begin
                    if (msg_last_i) begin
`ifdef KECCAK_ABSORB_PAD_EN
                        fsm_d = ST_PAD;
`else
                        fsm_d = ST_PERM;
`endif
                    end else if (idx_q == IDX_LAST) begin
                        fsm_d = ST_PERM;
                    end
                end
            end
`ifdef KECCAK_ABSORB_PAD_EN
            ST_PAD:  fsm_d = ST_PERM;
`endif
            ST_PERM: fsm_d = ST_WAIT;
            ST_WAIT: begin
                if (perm_done_i) begin
                    if (final_q) begin
                        fsm_d = ST_DONE;
`ifdef KECCAK_ABSORB_PAD_EN
                    end else if (pad_pending_q) begin
                        fsm_d = ST_PAD;
`endif
                    end else begin
                        fsm_d = ST_ABSORB;
                    end
                end
            end
            ST_DONE: begin
                if (digest_ready_i) begin
                    fsm_d = ST_ABSORB;
                end
            end
            default: fsm_d = ST_ABSORB;
        endcase
    end

    // FSM outputs; ready is forced low while reset is held.
    always_comb begin
        msg_ready_o    = (fsm_q == ST_ABSORB) & ~rst_i;
        perm_start_o   = (fsm_q == ST_PERM);
        digest_valid_o = (fsm_q == ST_DONE);
        perm_din_o     = state_q;
        digest_o       = state_q;
    end

    // Datapath registers: sponge state, word index, padding bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= '0;
            idx_q         <= '0;
            final_q       <= 1'b0;
`ifdef KECCAK_ABSORB_PAD_EN
            p_q           <= '0;
            pad_pending_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            final_q       <= final_d;
`ifdef KECCAK_ABSORB_PAD_EN
            p_q           <= p_d;
            pad_pending_q <= pad_pending_d;
`endif
        end
    end

    // Datapath next values, sequenced by the FSM state.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        final_d       = final_q;
`ifdef KECCAK_ABSORB_PAD_EN
        p_d           = p_q;
        pad_pending_d = pad_pending_q;
`endif
        case (fsm_q)
            ST_ABSORB: begin
                if (accept) begin
                    state_d = state_q ^ word_vec;
                    if (msg_last_i) begin
`ifdef KECCAK_ABSORB_PAD_EN
                        p_d     = p_new;
`else
                        final_d = 1'b1;
`endif
                    end else if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
`ifdef KECCAK_ABSORB_PAD_EN
            ST_PAD: begin
                // A full final block defers all padding to a fresh block.
                if (p_q == P_FULL) begin
                    pad_pending_d = 1'b1;
                end else begin
                    state_d = state_q ^ pad_vec;
                    final_d = 1'b1;
                end
            end
`endif
            ST_WAIT: begin
                if (perm_done_i) begin
                    state_d = perm_dout_i;
                    idx_d   = '0;
`ifdef KECCAK_ABSORB_PAD_EN
                    if (!final_q && pad_pending_q) begin
                        p_d           = '0;
                        pad_pending_d = 1'b0;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (digest_ready_i) begin
                    state_d = '0;
                    final_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule : keccak_absorb
`default_nettype wire

// File: tb/tb_keccak_absorb.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_absorb
// Description : Self-checking bench for keccak_absorb. A stand-in core with
//               programmable latency applies a simple mixing function; a
//               byte-level sponge model predicts every core input and the
//               final digest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_absorb;

    localparam int         RATE_W = 42;
    localparam logic [7:0] DSEP   = 8'h1F;
    localparam int         RB     = 4 * RATE_W;
`ifdef KECCAK_ABSORB_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          msg_valid_i, msg_ready_o, msg_last_i;
    logic [31:0]   msg_data_i;
    logic [2:0]    msg_bytes_i;
    logic          perm_start_o, perm_done_i;
    logic [1599:0] perm_din_o, perm_dout_i, digest_o;
    logic          digest_valid_o, digest_ready_i;

    keccak_absorb #(.RATE_W(RATE_W), .DSEP(DSEP)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .msg_valid_i    (msg_valid_i),
        .msg_ready_o    (msg_ready_o),
        .msg_data_i     (msg_data_i),
        .msg_bytes_i    (msg_bytes_i),
        .msg_last_i     (msg_last_i),
        .perm_start_o   (perm_start_o),
        .perm_din_o     (perm_din_o),
        .perm_dout_i    (perm_dout_i),
        .perm_done_i    (perm_done_i),
        .digest_valid_o (digest_valid_o),
        .digest_o       (digest_o),
        .digest_ready_i (digest_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int fb;
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            fb = 0;
            for (int j = 199; j >= 0; j--) if (act[8*j +: 8] !== exp[8*j +: 8]) fb = j;
            $display("FAIL %s: first differing byte %0d got %h want %h", name, fb,
                     act[8*fb +: 8], exp[8*fb +: 8]);
        end
    endtask

    // Stand-in permutation: rotate left by 7 and XOR a fixed pattern.
    function automatic logic [1599:0] perm_f(input logic [1599:0] x);
        return {x[1592:0], x[1599:1593]} ^ {50{32'h9E3779B9}};
    endfunction

    // ---------------- core model ----------------
    int            core_lat = 1;
    bit            busy = 0;
    int            cnt = 0;
    logic [1599:0] din_cap;
    logic [1599:0] din_q[$];
    int            start_cyc_q[$];
    int            done_cyc = 0;
    int            viol = 0;

    initial begin
        perm_done_i = 1'b0;
        perm_dout_i = '0;
        forever begin
            @(negedge clk_i);
            perm_done_i = 1'b0;
            if (rst_i) begin
                busy = 0;
            end else if (busy) begin
                if (perm_din_o !== din_cap) viol++;
                if (msg_ready_o) viol++;
                cnt--;
                if (cnt == 0) begin
                    perm_done_i = 1'b1;
                    perm_dout_i = perm_f(din_cap);
                    done_cyc    = cyc;
                    busy        = 0;
                end
            end else if (perm_start_o) begin
                din_cap = perm_din_o;
                din_q.push_back(perm_din_o);
                start_cyc_q.push_back(cyc);
                busy = 1;
                cnt  = core_lat;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]   stim_w[$];
    logic [1599:0] exp_din_q[$];
    logic [1599:0] exp_dig;

    task automatic model(input int beats, input int lbytes);
        byte unsigned m[$];
        byte unsigned p[0:1023];
        int L, total, nb;
        logic [1599:0] s;
        m.delete();
        for (int i = 0; i < beats; i++) begin
            nb = (PAD_EN && i == beats - 1) ? lbytes : 4;
            for (int k = 0; k < nb; k++) m.push_back(stim_w[i][8*k +: 8]);
        end
        L = m.size();
        if (PAD_EN) total = (L / RB + 1) * RB;
        else        total = ((L + RB - 1) / RB) * RB;
        for (int i = 0; i < 1024; i++) p[i] = (i < L) ? m[i] : 8'h00;
        if (PAD_EN) begin
            p[L]         = p[L] ^ DSEP;
            p[total - 1] = p[total - 1] ^ 8'h80;
        end
        exp_din_q.delete();
        s = '0;
        for (int b = 0; b < total / RB; b++) begin
            for (int j = 0; j < RB; j++) s[8*j +: 8] = s[8*j +: 8] ^ p[b*RB + j];
            exp_din_q.push_back(s);
            s = perm_f(s);
        end
        exp_dig = s;
    endtask

    // ---------------- stimulus ----------------
    task automatic send_beats(input int beats, input int lbytes, input int gap,
                              output int last_acc, output int full_acc, output bit ok);
        int  i, budget;
        bit  rdy, v;
        stim_w.delete();
        for (int k = 0; k < beats; k++) stim_w.push_back($urandom);
        i = 0; budget = 20000; ok = 1; last_acc = 0; full_acc = 0;
        while (i < beats) begin
            if (budget == 0) begin ok = 0; break; end
            budget--;
            if (gap != 0 && $urandom_range(0, 3) == 0) begin
                msg_valid_i = 1'b0;
            end else begin
                msg_valid_i = 1'b1;
                msg_data_i  = stim_w[i];
                msg_last_i  = (i == beats - 1);
                msg_bytes_i = (i == beats - 1) ? 3'(lbytes) : 3'($urandom_range(0, 4));
            end
            rdy = msg_ready_o;
            v   = msg_valid_i;
            @(posedge clk_i); #1;
            if (rdy && v) begin
                if (i == beats - 1) last_acc = cyc;
                if (i == RATE_W - 1) full_acc = cyc;
                i++;
            end
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
    endtask

    task automatic run_msg(input int beats, input int lbytes, input int lat, input int gap,
                           input int exp_perms);
        int la, fa, t, seen, n;
        bit ok, pending;
        core_lat = lat;
        din_q.delete();
        start_cyc_q.delete();
        viol = 0;
        send_beats(beats, lbytes, gap, la, fa, ok);
        chk("send_complete", ok, 1);
        model(beats, lbytes);
        t = 0;
        while (!digest_valid_o && t < 20000) begin @(posedge clk_i); #1; t++; end
        seen = cyc;
        chk("digest_valid", digest_valid_o, 1);
        chk("perm_count_model", din_q.size(), exp_din_q.size());
        if (exp_perms >= 0) chk("perm_count_table", din_q.size(), exp_perms);
        n = (din_q.size() < exp_din_q.size()) ? din_q.size() : exp_din_q.size();
        for (int k = 0; k < n; k++) chk_wide("perm_din", din_q[k], exp_din_q[k]);
        chk_wide("digest", digest_o, exp_dig);
        chk("return_latency", seen - done_cyc, 1);
        pending = PAD_EN && (beats % RATE_W == 0) && (lbytes == 4);
        if (!pending && start_cyc_q.size() > 0)
            chk("final_start_latency", start_cyc_q[$] - la, PAD_EN ? 1 : 0);
        if (beats > RATE_W && start_cyc_q.size() > 0)
            chk("block_start_latency", start_cyc_q[0] - fa, 0);
        chk("ready_low_din_stable", viol, 0);
        repeat ($urandom_range(1, 3)) begin @(posedge clk_i); #1; end
        chk("digest_valid_held", digest_valid_o, 1);
        digest_ready_i = 1'b1;
        @(posedge clk_i); #1;
        digest_ready_i = 1'b0;
        chk("digest_valid_cleared", digest_valid_o, 0);
        chk("ready_after_handshake", msg_ready_o, 1);
        chk_wide("state_cleared", digest_o, '0);
    endtask

    typedef struct {
        int beats;
        int lbytes;
        int lat;
        int gap;
        int exp_perms;
    } vec_t;

    vec_t tbl[7];

    initial begin : main
        logic [1599:0] empty_din;
        int la, fa, t;
        bit ok;

`ifdef KECCAK_ABSORB_PAD_EN
        tbl[0] = '{1,  0, 2,  0, 1};
        tbl[1] = '{42, 4, 5,  0, 2};
        tbl[2] = '{42, 3, 4,  1, 1};
        tbl[3] = '{84, 4, 24, 0, 3};
        tbl[4] = '{6,  2, 1,  1, 1};
        tbl[5] = '{43, 0, 7,  0, 2};
        tbl[6] = '{41, 4, 3,  0, 1};
`else
        tbl[0] = '{1,  0, 2,  0, 1};
        tbl[1] = '{42, 4, 5,  0, 1};
        tbl[2] = '{42, 3, 4,  1, 1};
        tbl[3] = '{84, 4, 24, 0, 2};
        tbl[4] = '{6,  2, 1,  1, 1};
        tbl[5] = '{43, 0, 7,  0, 2};
        tbl[6] = '{41, 4, 3,  0, 1};
`endif
        empty_din = '0;
        empty_din[7:0] = DSEP;
        empty_din[8*RB-1 -: 8] = 8'h80;

        rst_i = 1'b1;
        msg_valid_i = 1'b0; msg_data_i = '0; msg_bytes_i = '0; msg_last_i = 1'b0;
        digest_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ready", msg_ready_o, 0);
        chk("reset_start", perm_start_o, 0);
        chk("reset_digest_valid", digest_valid_o, 0);
        chk_wide("reset_din", perm_din_o, '0);
        chk_wide("reset_digest", digest_o, '0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_release", msg_ready_o, 1);
        @(posedge clk_i); #1;

        for (int i = 0; i < 7; i++)
            run_msg(tbl[i].beats, tbl[i].lbytes, tbl[i].lat, tbl[i].gap, tbl[i].exp_perms);

        // Empty message and last word in the final rate slot.
        run_msg(1, 0, 2, 0, 1);
`ifdef KECCAK_ABSORB_PAD_EN
        if (din_q.size() > 0) chk_wide("empty_din_literal", din_q[0], empty_din);
        run_msg(42, 3, 3, 0, 1);
        if (din_q.size() > 0) begin
            chk("coincident_pad_byte", din_q[0][8*RB-1 -: 8], 8'h9F);
            chk("last_word_data", din_q[0][8*RB-9 -: 24], stim_w[41][23:0]);
        end
`else
        run_msg(6, 4, 2, 0, 1);
        if (din_q.size() > 0) chk_wide("unused_rate_words_zero", {256'd0, din_q[0][1343:192], 192'd0}, '0);
`endif

        // Reset while the core is busy.
        core_lat = 24;
        din_q.delete();
        send_beats(3, 2, 0, la, fa, ok);
        t = 0;
        while (din_q.size() == 0 && t < 100) begin @(posedge clk_i); #1; t++; end
        chk("reset_test_started", din_q.size(), 1);
        repeat (3) begin @(posedge clk_i); #1; end
        #2 rst_i = 1'b1;
        #1;
        chk("midreset_ready", msg_ready_o, 0);
        chk("midreset_start", perm_start_o, 0);
        chk("midreset_digest_valid", digest_valid_o, 0);
        chk_wide("midreset_din", perm_din_o, '0);
        chk_wide("midreset_digest", digest_o, '0);
        #9 rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_reset_ready", msg_ready_o, 1);
        run_msg(1, 0, 2, 0, 1);
`ifdef KECCAK_ABSORB_PAD_EN
        if (din_q.size() > 0) chk_wide("post_reset_empty_din", din_q[0], empty_din);
`endif

        // Randomized messages.
        for (int r = 0; r < 6; r++)
            run_msg($urandom_range(1, 100), $urandom_range(0, 4), $urandom_range(1, 30),
                    $urandom_range(0, 1), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_keccak_absorb
`default_nettype wire
